// File: rtl/fat32_volume_parser.sv
`default_nettype none
// fat32_volume_parser: reads the MBR and FAT32 boot sector and derives absolute volume geometry.
// Optional macro SUPERFLOPPY_EN: accept an unpartitioned card whose sector 0 is itself the BPB.
module fat32_volume_parser #(
  parameter int SectorSize     = 512,
  parameter int AddressWidth   = 9,
  parameter int SectorWidth    = 32,
  parameter int PartitionIndex = 0
) (
  input  logic                    Clock,
  input  logic                    sys_rst,
  input  logic                    Start,
  output logic [SectorWidth-1:0]  RequestSector,
  output logic                    RequestValid,
  input  logic                    ByteValid,
  input  logic [AddressWidth-1:0] ByteAddress,
  input  logic [7:0]              ByteData,
  input  logic                    SectorDone,
  output logic                    Busy,
  output logic                    Done,
  output logic                    Error,
  output logic [2:0]              ErrorCode,
  output logic [SectorWidth-1:0]  PartitionStart,
  output logic [SectorWidth-1:0]  FatStart,
  output logic [SectorWidth-1:0]  DataStart,
  output logic [SectorWidth-1:0]  RootDirSector,
  output logic [7:0]              SectorsPerCluster,
  output logic [SectorWidth-1:0]  RootCluster
);

  localparam int Entry = 'h1BE + 16 * PartitionIndex;

  typedef enum logic [3:0] {
    S_IDLE, S_REQ_MBR, S_RD_MBR, S_CHK_MBR, S_REQ_BPB, S_RD_BPB,
    S_CHK_BPB, S_CALC_FAT, S_CALC_DATA, S_CALC_ROOT, S_DONE, S_ERROR
  } state_t;

  state_t state, state_n;
  logic [2:0]  code_n;

  logic [7:0]  mbr_sig0, mbr_sig1, part_type;
  logic [31:0] part_lba;
  logic [15:0] bps, rsvd;
  logic [7:0]  spc_cap, nfats, bsig0, bsig1;
  logic [31:0] fat_size, root_clus;

  logic [7:0]             cnt;
  logic [2:0]             spc_log, spc_log_n;
  logic [SectorWidth-1:0] shift_val, root_val;
  logic                   spc_pow2, is_fat32, bpb_capture;

`ifdef SUPERFLOPPY_EN
  assign bpb_capture = ByteValid && (state == S_RD_BPB || state == S_RD_MBR);
`else
  assign bpb_capture = ByteValid && (state == S_RD_BPB);
`endif

  assign Busy = !(state == S_IDLE || state == S_DONE || state == S_ERROR);

  always_ff @(posedge Clock) begin
    if (sys_rst) state <= S_IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n   = state;
    code_n    = 3'd0;
    spc_pow2  = (spc_cap != 8'd0) && ((spc_cap & (spc_cap - 8'd1)) == 8'd0);
    is_fat32  = (part_type == 8'h0B) || (part_type == 8'h0C);
    spc_log_n = 3'd0;
    for (int i = 0; i < 8; i++) if (spc_cap[i]) spc_log_n = 3'(i);
    // First root cycle seeds with cluster-2; later cycles double it (multiply by SPC).
    root_val  = (cnt == 8'd0) ? SectorWidth'(root_clus) - SectorWidth'(2) : shift_val << 1;
    case (state)
      S_IDLE, S_DONE, S_ERROR: if (Start) state_n = S_REQ_MBR;
      S_REQ_MBR: state_n = S_RD_MBR;
      S_RD_MBR:  if (SectorDone) state_n = S_CHK_MBR;
      S_CHK_MBR: begin
        if (!(mbr_sig0 == 8'h55 && mbr_sig1 == 8'hAA)) begin
          state_n = S_ERROR; code_n = 3'd1;
        end else if (is_fat32) begin
          state_n = S_REQ_BPB;
`ifdef SUPERFLOPPY_EN
        end else if (bps == 16'(SectorSize)) begin
          state_n = S_CHK_BPB;
`endif
        end else begin
          state_n = S_ERROR; code_n = 3'd2;
        end
      end
      S_REQ_BPB: state_n = S_RD_BPB;
      S_RD_BPB:  if (SectorDone) state_n = S_CHK_BPB;
      S_CHK_BPB: begin
        state_n = S_ERROR;
        if (!(bsig0 == 8'h55 && bsig1 == 8'hAA))           code_n = 3'd3;
        else if (bps != 16'(SectorSize))                   code_n = 3'd4;
        else if (!spc_pow2)                                code_n = 3'd5;
        else if (nfats == 8'd0 || root_clus < 32'd2)       code_n = 3'd6;
        else                                               state_n = S_CALC_FAT;
      end
      S_CALC_FAT:  state_n = S_CALC_DATA;
      S_CALC_DATA: if (cnt == 8'd1) state_n = S_CALC_ROOT;
      S_CALC_ROOT: if (cnt == {5'd0, spc_log}) state_n = S_DONE;
      default:     state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (sys_rst) begin
      RequestSector <= '0; RequestValid <= 1'b0;
      Done <= 1'b0; Error <= 1'b0; ErrorCode <= 3'd0;
      PartitionStart <= '0; FatStart <= '0; DataStart <= '0; RootDirSector <= '0;
      SectorsPerCluster <= 8'd0; RootCluster <= '0;
      mbr_sig0 <= 8'd0; mbr_sig1 <= 8'd0; part_type <= 8'd0; part_lba <= 32'd0;
      bps <= 16'd0; rsvd <= 16'd0; spc_cap <= 8'd0; nfats <= 8'd0;
      bsig0 <= 8'd0; bsig1 <= 8'd0; fat_size <= 32'd0; root_clus <= 32'd0;
      cnt <= 8'd0; spc_log <= 3'd0; shift_val <= '0;
    end else begin
      RequestValid <= (state_n == S_REQ_MBR) || (state_n == S_REQ_BPB);
      if (state_n == S_REQ_MBR) RequestSector <= '0;
      if (state_n == S_REQ_BPB) RequestSector <= SectorWidth'(part_lba);

      case (state)
        S_IDLE, S_DONE, S_ERROR: if (Start) begin
          Done <= 1'b0; Error <= 1'b0; ErrorCode <= 3'd0;
          mbr_sig0 <= 8'd0; mbr_sig1 <= 8'd0; part_type <= 8'd0; part_lba <= 32'd0;
          bps <= 16'd0; rsvd <= 16'd0; spc_cap <= 8'd0; nfats <= 8'd0;
          bsig0 <= 8'd0; bsig1 <= 8'd0; fat_size <= 32'd0; root_clus <= 32'd0;
        end
        S_CHK_MBR, S_CHK_BPB: begin
          if (state_n == S_ERROR) begin
            Error <= 1'b1; ErrorCode <= code_n;
          end
          if (state_n == S_REQ_BPB)                      PartitionStart <= SectorWidth'(part_lba);
          if (state == S_CHK_MBR && state_n == S_CHK_BPB) PartitionStart <= '0;
          if (state_n == S_CALC_FAT) begin
            SectorsPerCluster <= spc_cap;
            RootCluster       <= SectorWidth'(root_clus);
            spc_log           <= spc_log_n;
          end
        end
        S_CALC_FAT: begin
          FatStart  <= PartitionStart + SectorWidth'(rsvd);
          DataStart <= PartitionStart + SectorWidth'(rsvd);
          cnt       <= nfats;
        end
        S_CALC_DATA: begin
          DataStart <= DataStart + SectorWidth'(fat_size);
          cnt       <= cnt - 8'd1;
        end
        S_CALC_ROOT: begin
          shift_val <= root_val;
          cnt       <= cnt + 8'd1;
          if (state_n == S_DONE) begin
            RootDirSector <= DataStart + root_val;
            Done          <= 1'b1;
          end
        end
        default: ;
      endcase

      if (ByteValid && state == S_RD_MBR) begin
        case (ByteAddress)
          AddressWidth'('h1FE):      mbr_sig0       <= ByteData;
          AddressWidth'('h1FF):      mbr_sig1       <= ByteData;
          AddressWidth'(Entry + 4):  part_type      <= ByteData;
          AddressWidth'(Entry + 8):  part_lba[7:0]   <= ByteData;
          AddressWidth'(Entry + 9):  part_lba[15:8]  <= ByteData;
          AddressWidth'(Entry + 10): part_lba[23:16] <= ByteData;
          AddressWidth'(Entry + 11): part_lba[31:24] <= ByteData;
          default: ;
        endcase
      end

      if (bpb_capture) begin
        case (ByteAddress)
          AddressWidth'('h0B): bps[7:0]         <= ByteData;
          AddressWidth'('h0C): bps[15:8]        <= ByteData;
          AddressWidth'('h0D): spc_cap          <= ByteData;
          AddressWidth'('h0E): rsvd[7:0]        <= ByteData;
          AddressWidth'('h0F): rsvd[15:8]       <= ByteData;
          AddressWidth'('h10): nfats            <= ByteData;
          AddressWidth'('h24): fat_size[7:0]    <= ByteData;
          AddressWidth'('h25): fat_size[15:8]   <= ByteData;
          AddressWidth'('h26): fat_size[23:16]  <= ByteData;
          AddressWidth'('h27): fat_size[31:24]  <= ByteData;
          AddressWidth'('h2C): root_clus[7:0]   <= ByteData;
          AddressWidth'('h2D): root_clus[15:8]  <= ByteData;
          AddressWidth'('h2E): root_clus[23:16] <= ByteData;
          AddressWidth'('h2F): root_clus[31:24] <= ByteData;
          AddressWidth'('h1FE): bsig0           <= ByteData;
          AddressWidth'('h1FF): bsig1           <= ByteData;
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
